// File: rtl/debug_pkg.sv
// Shared debugger-unit definitions: FSM state encodings, UART byte width and
// the program-load terminator word. Used by both the snapshot sender and the
// receive-side program loader.
package debug_pkg;

  localparam int unsigned UART_BYTE_W = 8;

  // 3-bit state encodings shared by the debugger FSMs
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_RECV  = 3'd1;
  localparam logic [2:0] ST_WRITE = 3'd2;
  localparam logic [2:0] ST_DONE  = 3'd3;
  localparam logic [2:0] ST_ABORT = 3'd4;

  localparam logic [31:0] DEBUG_END_WORD = 32'hFFFF_FFFF;

endpackage

// File: rtl/rx_word_assembler.sv
// Byte-lane assembler: packs successive UART bytes into a DATA_W-bit word,
// first byte in bits [7:0]. word_next is the word including the byte being
// accepted this cycle, so the owner can act on a completed word without an
// extra cycle of latency; word_valid marks the byte that completes a word.
module rx_word_assembler
  import debug_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  input  logic                   byte_valid,
  input  logic [UART_BYTE_W-1:0] byte_data,
  output logic                   word_valid,
  output logic [DATA_W-1:0]      word_next
);

  localparam int unsigned BYTES = DATA_W / UART_BYTE_W;
  localparam int unsigned IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES - 1);

  logic [IDX_W-1:0]  idx_q;
  logic [DATA_W-1:0] word_q;

  assign word_valid = byte_valid && (idx_q == LAST_IDX);

  // Merge the incoming byte into its lane
  always_comb begin
    word_next = word_q;
    if (byte_valid) begin
      word_next[idx_q*UART_BYTE_W +: UART_BYTE_W] = byte_data;
    end
  end

  // Lane index and shift register; index wraps after the last lane
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q  <= '0;
      word_q <= '0;
    end else if (clear) begin
      idx_q  <= '0;
      word_q <= '0;
    end else if (byte_valid) begin
      word_q <= word_next;
      idx_q  <= word_valid ? '0 : idx_q + IDX_W'(1);
    end
  end

endmodule

// File: rtl/debug_rx_loader.sv
// UART-side program loader: assembles received bytes into words and writes
// them to instruction memory from address 0 until the terminator word or
// MAX_WORDS writes, then pulses os_done.
// Optional feature macro: DEBUG_RX_TIMEOUT_EN adds an inter-byte timeout that
// aborts the load (os_error pulse); without it os_error is tied 0.
module debug_rx_loader
  import debug_pkg::*;
#(
  parameter int unsigned       DATA_W      = 32,
  parameter int unsigned       ADDR_W      = 10,
  parameter int unsigned       MAX_WORDS   = 1024,
  parameter logic [DATA_W-1:0] END_WORD    = DATA_W'(DEBUG_END_WORD),
  parameter int unsigned       TIMEOUT_CYC = 1_000_000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   is_start,
  input  logic [UART_BYTE_W-1:0] i_rx_data,
  input  logic                   is_rx_done,
  output logic                   o_wr_en,
  output logic [ADDR_W-1:0]      o_wr_addr,
  output logic [DATA_W-1:0]      o_wr_data,
  output logic [ADDR_W:0]        o_word_count,
  output logic                   os_busy,
  output logic                   os_done,
  output logic                   os_error
);

  localparam logic [ADDR_W:0] LAST_COUNT = (ADDR_W + 1)'(MAX_WORDS - 1);

  // Elaboration-time parameter sanity checks
  if ((DATA_W % UART_BYTE_W) != 0 || DATA_W == 0) begin : g_bad_data_w
    $error("debug_rx_loader: DATA_W must be a non-zero multiple of 8");
  end
  if (MAX_WORDS == 0 || MAX_WORDS > (1 << ADDR_W)) begin : g_bad_max_words
    $error("debug_rx_loader: MAX_WORDS must be in 1..2**ADDR_W");
  end
  if (TIMEOUT_CYC < 2) begin : g_bad_timeout
    $error("debug_rx_loader: TIMEOUT_CYC must be at least 2");
  end

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W:0]   count_q;
  logic              wr_en_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [DATA_W-1:0] wr_data_q;

  logic              start;
  logic              in_recv;
  logic              in_write;
  logic              last_write;
  logic              capture_en;
  logic              byte_valid;
  logic              word_valid;
  logic [DATA_W-1:0] word_next;
  logic              is_end;
  logic              load_word;
  logic              timeout_hit;

  assign in_recv    = (state_q == ST_RECV);
  assign in_write   = (state_q == ST_WRITE);
  assign start      = (state_q == ST_IDLE) && is_start;
  assign last_write = in_write && (count_q == LAST_COUNT);
  // A byte arriving in the WRITE cycle starts the next word, unless the load
  // is about to finish on MAX_WORDS.
  assign capture_en = in_recv || (in_write && !last_write);
  assign byte_valid = is_rx_done && capture_en;
  assign is_end     = (word_next == END_WORD);
  assign load_word  = word_valid && !is_end;

  rx_word_assembler #(
    .DATA_W (DATA_W)
  ) u_assembler (
    .clk        (clk),
    .rst        (rst),
    .clear      (start),
    .byte_valid (byte_valid),
    .byte_data  (i_rx_data),
    .word_valid (word_valid),
    .word_next  (word_next)
  );

`ifdef DEBUG_RX_TIMEOUT_EN
  localparam int unsigned TMR_W = $clog2(TIMEOUT_CYC + 1);

  logic [TMR_W-1:0] timer_q;

  assign timeout_hit = in_recv && !is_rx_done && (timer_q == TMR_W'(TIMEOUT_CYC - 1));
  assign os_error    = (state_q == ST_ABORT);

  // Inter-byte timer: restarts on every byte and on start, runs while in RECV
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer_q <= '0;
    end else if (start || is_rx_done) begin
      timer_q <= '0;
    end else if (in_recv) begin
      timer_q <= timer_q + TMR_W'(1);
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign os_error    = 1'b0;
`endif

  // Next-state decode
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (is_start) state_d = ST_RECV;
      end
      ST_RECV: begin
        if (word_valid)       state_d = is_end ? ST_DONE : ST_WRITE;
        else if (timeout_hit) state_d = ST_ABORT;
      end
      ST_WRITE: begin
        if (last_write)      state_d = ST_DONE;
        else if (word_valid) state_d = is_end ? ST_DONE : ST_WRITE;
        else                 state_d = ST_RECV;
      end
      ST_DONE:  state_d = ST_IDLE;
      ST_ABORT: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next write address advances per accepted word; count advances in WRITE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q  <= '0;
      count_q <= '0;
    end else if (start) begin
      addr_q  <= '0;
      count_q <= '0;
    end else begin
      if (load_word) addr_q  <= addr_q + ADDR_W'(1);
      if (in_write)  count_q <= count_q + (ADDR_W + 1)'(1);
    end
  end

  // Registered memory write port; address/data hold between writes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      wr_en_q <= load_word;
      if (load_word) begin
        wr_addr_q <= addr_q;
        wr_data_q <= word_next;
      end
    end
  end

  assign o_wr_en      = wr_en_q;
  assign o_wr_addr    = wr_addr_q;
  assign o_wr_data    = wr_data_q;
  assign o_word_count = count_q;
  assign os_busy      = in_recv || in_write;
  assign os_done      = (state_q == ST_DONE);

endmodule
